div_cfg_ctrl: RTL

- Configuration sequencer for the 15-bit programmable clock divider: debounces the switch-supplied divide ratio, clamps illegal values, and applies each new ratio glitch-safely by holding the divider in reset while the ratio changes.
- Confirms lock by measuring the divided clock's period against the programmed ratio, then keeps monitoring it.
- Sits between the board switches and the divider instance, in the 100 MHz system clock domain.

---
 rtl/div_cfg_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/div_cfg_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : div_cfg_ctrl
// Description : Configuration sequencer for a 15-bit programmable clock
//               divider. Debounces the switch ratio, clamps it to MIN_N,
//               reprograms the divider while holding it in reset, then
//               measures the divided clock period and keeps checking it.
// Ports       : clk, rst_n          - system clock, async active-low reset
//               sw_n[14:0]          - raw requested ratio (asynchronous)
//               div_clk_i           - divided clock fed back (asynchronous)
//               div_n[14:0]         - ratio driven to the divider
//               div_rst_n           - active-low reset to the divider
//               busy / locked       - reconfiguring / period confirmed
//               clamped / fault     - ratio clamped / period check failed
//               cfg_done            - one-cycle pulse on entering LOCKED
// Revision    : 1.0 - initial release
// ============================================================================
module div_cfg_ctrl #(
  parameter int DEB_CYCLES  = 1000000,
  parameter int HOLD_CYCLES = 4,
  parameter int MIN_N       = 2,
  parameter int TOL         = 1,
  parameter int TMO_CYCLES  = 131072
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [14:0] sw_n,
  input  logic        div_clk_i,
  output logic [14:0] div_n,
  output logic        div_rst_n,
  output logic        busy,
  output logic        locked,
  output logic        clamped,
  output logic        fault,
  output logic        cfg_done
);

  localparam int c_DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int c_HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [c_DEB_W-1:0]  c_DEB_LAST  = c_DEB_W'(DEB_CYCLES - 1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [17:0]         c_TMO       = 18'(TMO_CYCLES);
  localparam logic [17:0]         c_TOL       = 18'(TOL);
  localparam logic [14:0]         c_MIN_N     = 15'(MIN_N);

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_MEASURE = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  state_t              r_state;
  logic [14:0]         r_sw_s1, r_sw_s2, r_sw_last, r_sw_stable;
  logic [c_DEB_W-1:0]  r_deb_cnt;
  logic                r_dc_s1, r_dc_s2, r_dc_prev;
  logic [c_HOLD_W-1:0] r_hold_cnt;
  logic [17:0]         r_tmo_cnt, r_per_cnt;

  logic        w_edge_p;
  logic        w_clamp_req;
  logic [14:0] w_target;
  logic        w_new_req;
  logic [17:0] w_tmo_next, w_per_next, w_div_ext, w_diff;
  logic        w_match;

  // ---------------- input synchronisers and debouncer ----------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_s1     <= '0;
      r_sw_s2     <= '0;
      r_sw_last   <= '0;
      r_sw_stable <= '0;
      r_deb_cnt   <= '0;
      r_dc_s1     <= 1'b0;
      r_dc_s2     <= 1'b0;
      r_dc_prev   <= 1'b0;
    end else begin
      r_sw_s1   <= sw_n;
      r_sw_s2   <= r_sw_s1;
      r_dc_s1   <= div_clk_i;
      r_dc_s2   <= r_dc_s1;
      r_dc_prev <= r_dc_s2;
      if (r_sw_s2 != r_sw_last) begin
        r_sw_last <= r_sw_s2;
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == c_DEB_LAST) begin
        // Counter parks here; re-accepting the same value is harmless.
        r_sw_stable <= r_sw_last;
      end else begin
        r_deb_cnt <= r_deb_cnt + 1'b1;
      end
    end
  end

  assign w_edge_p    = r_dc_s2 & ~r_dc_prev;
  assign w_clamp_req = (r_sw_stable < c_MIN_N);
  assign w_target    = w_clamp_req ? c_MIN_N : r_sw_stable;
  assign w_new_req   = (w_target != div_n);

  // Both measurement counters saturate at the timeout value.
  assign w_tmo_next = (r_tmo_cnt == c_TMO) ? c_TMO : r_tmo_cnt + 18'd1;
  assign w_per_next = (r_per_cnt == c_TMO) ? c_TMO : r_per_cnt + 18'd1;
  assign w_div_ext  = {3'b000, div_n};
  assign w_diff     = (r_per_cnt >= w_div_ext) ? (r_per_cnt - w_div_ext)
                                               : (w_div_ext - r_per_cnt);
  assign w_match    = (w_diff <= c_TOL);

  // ---------------- sequencer ----------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_HOLD;
      div_n      <= c_MIN_N;
      div_rst_n  <= 1'b0;
      busy       <= 1'b1;
      locked     <= 1'b0;
      clamped    <= 1'b0;
      fault      <= 1'b0;
      cfg_done   <= 1'b0;
      r_hold_cnt <= '0;
      r_tmo_cnt  <= '0;
      r_per_cnt  <= '0;
    end else begin
      cfg_done <= 1'b0;
      // The first HOLD cycle is the one that loads the target, so a pending
      // request there is already being serviced and must not restart HOLD.
      if (w_new_req && !(r_state == ST_HOLD && r_hold_cnt == '0)) begin
        r_state    <= ST_HOLD;
        r_hold_cnt <= '0;
        div_rst_n  <= 1'b0;
        busy       <= 1'b1;
        locked     <= 1'b0;
        fault      <= 1'b0;
        r_tmo_cnt  <= '0;
        r_per_cnt  <= '0;
      end else begin
        case (r_state)
          ST_HOLD: begin
            if (r_hold_cnt == '0) begin
              div_n   <= w_target;
              clamped <= w_clamp_req;
            end
            if (r_hold_cnt == c_HOLD_LAST) begin
              r_state    <= ST_WAIT;
              div_rst_n  <= 1'b1;
              r_hold_cnt <= '0;
              r_tmo_cnt  <= '0;
            end else begin
              r_hold_cnt <= r_hold_cnt + 1'b1;
            end
          end
          ST_WAIT: begin
            r_tmo_cnt <= w_tmo_next;
            if (w_edge_p) begin
              r_state   <= ST_MEASURE;
              r_per_cnt <= 18'd1;
            end else if (w_tmo_next == c_TMO) begin
              r_state <= ST_FAULT;
              fault   <= 1'b1;
              busy    <= 1'b0;
              locked  <= 1'b0;
            end
          end
          ST_MEASURE, ST_LOCKED: begin
            if (w_edge_p) begin
              if (w_match) begin
                r_per_cnt <= 18'd1;
                if (r_state == ST_MEASURE) begin
                  r_state  <= ST_LOCKED;
                  cfg_done <= 1'b1;
                  busy     <= 1'b0;
                  locked   <= 1'b1;
                end
              end else begin
                r_state <= ST_FAULT;
                fault   <= 1'b1;
                busy    <= 1'b0;
                locked  <= 1'b0;
              end
            end else begin
              r_per_cnt <= w_per_next;
              if (w_per_next == c_TMO) begin
                r_state <= ST_FAULT;
                fault   <= 1'b1;
                busy    <= 1'b0;
                locked  <= 1'b0;
              end
            end
          end
          ST_FAULT: begin
            // Parked until a new request arrives.
          end
          default: begin
            r_state <= ST_HOLD;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
